// File: rtl/lsu_access_unit_pkg.sv
// Shared definitions for the load/store unit: width encodings, FSM states, size/mask helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_access_unit_pkg;

  // One-hot access width encodings as seen on width_1h_i
  localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
  localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
  localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
  localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

  // Access FSM; REQ2/WAIT2 only carry the second beat of a word-crossing access
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // Access size in bytes; zero for a malformed width (such accesses never reach the bus)
  function automatic logic [3:0] width_size(input logic [3:0] width_1h);
    logic [3:0] size;
    case (width_1h)
      MEM_WIDTH_1H_BYTE:   size = 4'd1;
      MEM_WIDTH_1H_HALF:   size = 4'd2;
      MEM_WIDTH_1H_WORD:   size = 4'd4;
      MEM_WIDTH_1H_DOUBLE: size = 4'd8;
      default:             size = 4'd0;
    endcase
    return size;
  endfunction

  // Byte-lane mask for an access starting at lane 0
  function automatic logic [7:0] width_mask(input logic [3:0] width_1h);
    logic [7:0] mask;
    case (width_1h)
      MEM_WIDTH_1H_BYTE:   mask = 8'h01;
      MEM_WIDTH_1H_HALF:   mask = 8'h03;
      MEM_WIDTH_1H_WORD:   mask = 8'h0F;
      MEM_WIDTH_1H_DOUBLE: mask = 8'hFF;
      default:             mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load realignment: joins the low/high bus words, shifts the addressed bytes to bit 0, masks, extends.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module lsu_load_align
  import lsu_access_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  lo,
  input  logic [XLEN-1:0]  hi,
  input  logic [OFF_W-1:0] off,
  input  logic [3:0]       width_1h,
  input  logic             sign,
  output logic [XLEN-1:0]  rdata
);

  logic [7:0]             sh_lo;
  logic [7:0]             sh_hi;
  logic [7:0]             keep;
  logic [XLEN-1:0]        joined;
  logic [XLEN-1:0]        up;
  logic [XLEN-1:0]        zx;
  logic signed [XLEN-1:0] sx;

  // Shift the addressed bytes down, then push them to the top and back to extend in one step.
  // A shift of XLEN (off = 0 on the high word) yields zero, which is what a single beat needs.
  always_comb begin
    sh_lo  = 8'({off, 3'b000});
    sh_hi  = 8'(XLEN) - sh_lo;
    joined = (lo >> sh_lo) | (hi << sh_hi);
    keep   = 8'(XLEN) - 8'({width_size(width_1h), 3'b000});
    up     = joined << keep;
    zx     = up >> keep;
    sx     = $signed(up) >>> keep;
    rdata  = sign ? sx : zx;
  end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store unit: one request per handshake, OBI data-memory beats, aligned/extended load result.
// Latency: aligned access with immediate gnt/rvalid returns valid_o 3 cycles after accept; illegal in 1.
// Backpressure: ready_o only in IDLE; result held on valid_o until ready_i; req held until gnt.
// Build option: define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two beats.
module lsu_access_unit
  import lsu_access_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              squash_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [3:0]        width_1h_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              sign_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic              dmem_we_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              illegal_o
);

  localparam int NB = XLEN/8;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_t state, state_next;
  logic       beat2;
  logic       accept;

  // Request decode
  logic [OFF_W-1:0] off_in;
  logic [3:0]       size_in;
  logic [4:0]       end_in;
  logic             cross_in;
  logic             width_bad;
  logic             illegal_in;
  logic [15:0]      be_span;
  logic [7:0]       sh_in;
  logic [XLEN-1:0]  wdata_rot;

  // Captured transaction
  logic [XLEN-1:0]  addr_q;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       width_q;
  logic             sign_q;
  logic             we_q;
  logic             cross_q;
  logic [NB-1:0]    be1_q;
  logic [NB-1:0]    be2_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  rdata_q;
  logic             illegal_q;

  logic [XLEN-1:0]  align_lo;
  logic [XLEN-1:0]  align_hi;
  logic [XLEN-1:0]  align_out;

  assign accept    = valid_i & ready_o & ~squash_i;
  assign off_in    = addr_i[OFF_W-1:0];
  assign size_in   = width_size(width_1h_i);
  assign end_in    = 5'(off_in) + 5'(size_in);
  assign cross_in  = end_in > 5'(NB);
  assign width_bad = !$onehot(width_1h_i) || ((XLEN == 32) && (width_1h_i == MEM_WIDTH_1H_DOUBLE));
  assign illegal_in = width_bad | (rd_i & wr_i) | (cross_in & ~SPLIT_EN);
  // Lanes of both beats in one shift: low NB bits are beat 1, the spill-over is beat 2
  assign be_span   = 16'(width_mask(width_1h_i)) << off_in;
  assign sh_in     = 8'({off_in, 3'b000});
  assign wdata_rot = (wdata_i << sh_in) | (wdata_i >> (8'(XLEN) - sh_in));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next state and FSM-decoded outputs
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    dmem_req_o = 1'b0;
    valid_o    = 1'b0;
    beat2      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !squash_i) state_next = illegal_in ? ST_RESP : ST_REQ1;
      end
      ST_REQ1: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) state_next = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (dmem_rvalid_i) state_next = cross_q ? ST_REQ2 : ST_RESP;
      end
      ST_REQ2: begin
        dmem_req_o = 1'b1;
        beat2      = 1'b1;
        if (dmem_gnt_i) state_next = ST_WAIT2;
      end
      ST_WAIT2: begin
        beat2 = 1'b1;
        if (dmem_rvalid_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        valid_o = 1'b1;
        if (ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // On the second beat the first word is already in lo_q and the live bus word is the high half
  assign align_lo = (state == ST_WAIT2) ? lo_q : dmem_rdata_i;
  assign align_hi = (state == ST_WAIT2) ? dmem_rdata_i : '0;

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .lo       (align_lo),
    .hi       (align_hi),
    .off      (off_q),
    .width_1h (width_q),
    .sign     (sign_q),
    .rdata    (align_out)
  );

  // Capture the request on accept and the load data as each beat returns
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      off_q     <= '0;
      width_q   <= '0;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      cross_q   <= 1'b0;
      be1_q     <= '0;
      be2_q     <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        illegal_q <= illegal_in;
        rdata_q   <= '0;
        if (!illegal_in) begin
          addr_q  <= {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          off_q   <= off_in;
          width_q <= width_1h_i;
          sign_q  <= sign_i;
          we_q    <= wr_i;
          cross_q <= cross_in;
          be1_q   <= be_span[NB-1:0];
          be2_q   <= be_span[2*NB-1:NB];
          wdata_q <= wdata_rot;
        end
      end
      if ((state == ST_WAIT1) && dmem_rvalid_i) begin
        lo_q <= dmem_rdata_i;
        if (!cross_q) rdata_q <= we_q ? '0 : align_out;
      end
      if ((state == ST_WAIT2) && dmem_rvalid_i) begin
        rdata_q <= we_q ? '0 : align_out;
      end
    end
  end

  assign dmem_addr_o  = beat2 ? (addr_q + XLEN'(NB)) : addr_q;
  assign dmem_be_o    = beat2 ? be2_q : be1_q;
  assign dmem_we_o    = we_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;
  assign illegal_o    = illegal_q & valid_o;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Bench for lsu_access_unit (XLEN=64): directed vectors, expected beats/results queued at issue,
// a negedge monitor pops and compares on each grant and each accepted result.
// A small memory responder returns rvalid one cycle after each grant.
module tb_lsu_access_unit;

  localparam int XLEN = 64;
  localparam logic [3:0] W_B = 4'b0001;
  localparam logic [3:0] W_H = 4'b0010;
  localparam logic [3:0] W_W = 4'b0100;
  localparam logic [3:0] W_D = 4'b1000;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i, ready_o, squash_i;
  logic [XLEN-1:0] addr_i, wdata_i;
  logic [3:0]      width_1h_i;
  logic            rd_i, wr_i, sign_i;
  logic            dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
  logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [7:0]      dmem_be_o;
  logic            valid_o, ready_i, illegal_o;
  logic [XLEN-1:0] rdata_o;

  always #5 clk_i = ~clk_i;

  lsu_access_unit #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .squash_i(squash_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .width_1h_i(width_1h_i), .rd_i(rd_i), .wr_i(wr_i),
    .sign_i(sign_i), .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .ready_i(ready_i), .rdata_o(rdata_o), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] rsp;
  } bus_t;

  typedef struct {
    logic [63:0] rdata;
    logic        ill;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  int          n_chk = 0;
  int          n_pass = 0;
  int          req_seen = 0;
  logic        granted = 1'b0;
  logic        rsp_en = 1'b1;
  logic [63:0] next_rsp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic exp_bus(input logic [63:0] a, input logic we, input logic [7:0] be,
                         input logic [63:0] wd, input logic [63:0] rsp);
    bus_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.rsp = rsp;
    bus_q.push_back(b);
  endtask

  task automatic exp_res(input logic [63:0] rd, input logic ill);
    res_t r;
    r.rdata = rd; r.ill = ill;
    res_q.push_back(r);
  endtask

  // Monitor: every granted beat and every accepted result is compared against the queues
  always @(negedge clk_i) begin : mon
    bus_t b;
    res_t r;
    if (dmem_req_o) req_seen++;
    if (rst_ni && dmem_req_o && dmem_gnt_i) begin
      if (bus_q.size() == 0) begin
        n_chk++;
        $display("FAIL bus_unexpected: beat at addr 0x%0h, required no beat", dmem_addr_o);
      end else begin
        b = bus_q.pop_front();
        check("bus_addr", dmem_addr_o, b.addr);
        check("bus_we", 64'(dmem_we_o), 64'(b.we));
        check("bus_be", 64'(dmem_be_o), 64'(b.be));
        check("bus_wdata", dmem_wdata_o, b.wdata);
        next_rsp = b.rsp;
        granted  = 1'b1;
      end
    end
    if (rst_ni && valid_o && ready_i) begin
      if (res_q.size() == 0) begin
        n_chk++;
        $display("FAIL res_unexpected: result 0x%0h, required no result", rdata_o);
      end else begin
        r = res_q.pop_front();
        check("res_rdata", rdata_o, r.rdata);
        check("res_illegal", 64'(illegal_o), 64'(r.ill));
      end
    end
  end

  // Memory responder: one rvalid the cycle after each grant
  always @(posedge clk_i) begin
    #1;
    dmem_rvalid_i = granted & rsp_en;
    dmem_rdata_i  = granted ? next_rsp : '0;
    granted       = 1'b0;
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] w,
                       input logic rd, input logic wr, input logic sg, input logic sq);
    @(posedge clk_i); #1;
    addr_i = a; wdata_i = wd; width_1h_i = w; rd_i = rd; wr_i = wr; sign_i = sg;
    squash_i = sq; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; squash_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!valid_o && lat < 20);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while ((res_q.size() != 0) && (k < 60)) begin
      @(negedge clk_i);
      k++;
    end
    check({nm, "_drained"}, 64'(res_q.size() + bus_q.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int lat;
    int rs;
    rst_ni = 1'b0; valid_i = 1'b0; squash_i = 1'b0; addr_i = '0; wdata_i = '0;
    width_1h_i = W_B; rd_i = 1'b0; wr_i = 1'b0; sign_i = 1'b0; dmem_gnt_i = 1'b1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; ready_i = 1'b1;

    // Reset state
    #1;
    check("rst_req", 64'(dmem_req_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_addr", dmem_addr_o, 64'd0);
    check("rst_be", 64'(dmem_be_o), 64'd0);
    check("rst_wdata", dmem_wdata_o, 64'd0);
    check("rst_we", 64'(dmem_we_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_ready", 64'(ready_o), 64'd1);

    // SW, offset 4
    exp_bus(64'h1000, 1'b1, 8'hF0, 64'hDEADBEEF_00000000, 64'd0);
    exp_res(64'd0, 1'b0);
    issue(64'h1004, 64'hDEADBEEF, W_W, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done("sw");

    // LB signed, offset 3, minimum latency
    exp_bus(64'h2000, 1'b0, 8'h08, 64'd0, 64'h00000000_80000000);
    exp_res(64'hFFFFFFFF_FFFFFF80, 1'b0);
    issue(64'h2003, 64'd0, W_B, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_valid(lat);
    check("lb_latency", 64'(lat), 64'd3);
    wait_done("lb");

    // LHU, offset 6
    exp_bus(64'h2100, 1'b0, 8'hC0, 64'd0, 64'h12345678_9ABCDEF0);
    exp_res(64'h1234, 1'b0);
    issue(64'h2106, 64'd0, W_H, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done("lhu");

    // LW signed, offset 4
    exp_bus(64'h2200, 1'b0, 8'hF0, 64'd0, 64'h87654321_00000000);
    exp_res(64'hFFFFFFFF_87654321, 1'b0);
    issue(64'h2204, 64'd0, W_W, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done("lw");

    // LD aligned
    exp_bus(64'h2300, 1'b0, 8'hFF, 64'd0, 64'hCAFEBABE_01234567);
    exp_res(64'hCAFEBABE_01234567, 1'b0);
    issue(64'h2300, 64'd0, W_D, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done("ld");

    // SH, offset 2: data rotated left by 16
    exp_bus(64'h2400, 1'b1, 8'h0C, 64'h22223333_ABCD1111, 64'd0);
    exp_res(64'd0, 1'b0);
    issue(64'h2402, 64'h11112222_3333ABCD, W_H, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done("sh");

    // Malformed width: flagged next cycle, no bus activity
    rs = req_seen;
    exp_res(64'd0, 1'b1);
    issue(64'h2500, 64'd0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    check("badw_latency", 64'(lat), 64'd1);
    wait_done("badw");
    check("badw_noreq", 64'(req_seen - rs), 64'd0);

    // Load and store together
    rs = req_seen;
    exp_res(64'd0, 1'b1);
    issue(64'h2600, 64'd0, W_W, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done("rdwr");
    check("rdwr_noreq", 64'(req_seen - rs), 64'd0);

`ifdef LSU_MISALIGNED_SPLIT_EN
    // LW crossing the word: two beats, halves reassembled
    exp_bus(64'h3000, 1'b0, 8'hC0, 64'd0, 64'hAABB0000_00000000);
    exp_bus(64'h3008, 1'b0, 8'h03, 64'd0, 64'h00000000_0000CCDD);
    exp_res(64'h00000000_CCDDAABB, 1'b0);
    issue(64'h3006, 64'd0, W_W, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done("split");
`else
    // LD crossing the word: illegal, no bus activity
    rs = req_seen;
    exp_res(64'd0, 1'b1);
    issue(64'h3004, 64'd0, W_D, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    check("cross_latency", 64'(lat), 64'd1);
    wait_done("cross");
    check("cross_noreq", 64'(req_seen - rs), 64'd0);
`endif

    // Squash in the accepting cycle: nothing happens
    rs = req_seen;
    issue(64'h2000, 64'd0, W_B, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk_i);
    check("squash_noreq", 64'(req_seen - rs), 64'd0);
    check("squash_novalid", 64'(valid_o), 64'd0);
    check("squash_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;

    // Grant withheld 5 cycles: request fields stable
    dmem_gnt_i = 1'b0;
    exp_bus(64'h4008, 1'b1, 8'hFF, 64'h01020304_05060708, 64'd0);
    exp_res(64'd0, 1'b0);
    issue(64'h4008, 64'h01020304_05060708, W_D, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk_i);
      check("stall_req", 64'(dmem_req_o), 64'd1);
      check("stall_addr", dmem_addr_o, 64'h4008);
      check("stall_be", 64'(dmem_be_o), 64'hFF);
      check("stall_wdata", dmem_wdata_o, 64'h01020304_05060708);
    end
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b1;
    wait_done("stall");

    // Writeback stalls 3 cycles in RESP: result held, no accept
    ready_i = 1'b0;
    exp_bus(64'h2000, 1'b0, 8'h08, 64'd0, 64'h00000000_80000000);
    exp_res(64'hFFFFFFFF_FFFFFF80, 1'b0);
    issue(64'h2003, 64'd0, W_B, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      check("hold_ready", 64'(ready_o), 64'd0);
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_rdata", rdata_o, 64'hFFFFFFFF_FFFFFF80);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    wait_done("hold");

    // Reset while a request waits for grant: req drops at once
    dmem_gnt_i = 1'b0;
    issue(64'h5000, 64'd0, W_D, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("rreq_pre", 64'(dmem_req_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("rreq_req", 64'(dmem_req_o), 64'd0);
    check("rreq_valid", 64'(valid_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1; dmem_gnt_i = 1'b1;

    // Reset in WAIT1
    rsp_en = 1'b0;
    exp_bus(64'h5000, 1'b0, 8'hFF, 64'd0, 64'd0);
    issue(64'h5000, 64'd0, W_D, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #2;
    check("rwait_busy", 64'(ready_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    check("rwait_req", 64'(dmem_req_o), 64'd0);
    check("rwait_valid", 64'(valid_o), 64'd0);
    check("rwait_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i); rst_ni = 1'b1; rsp_en = 1'b1;

    // Recovery after reset
    exp_bus(64'h2300, 1'b0, 8'hFF, 64'd0, 64'h0BADF00D_12345678);
    exp_res(64'h0BADF00D_12345678, 1'b0);
    issue(64'h2300, 64'd0, W_D, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done("recover");

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
